// File: rtl/btn_event_decoder_if.sv
// rtl/btn_event_decoder_if.sv - button level in, user event pulses out
interface btn_event_decoder_if;
    logic btn_level;
    logic enable;
    logic short_press;
    logic double_click;
    logic long_press;
    logic repeat_tick;
    logic held;

    modport master (
        output btn_level,
        output enable,
        input  short_press,
        input  double_click,
        input  long_press,
        input  repeat_tick,
        input  held
    );

    modport slave (
        input  btn_level,
        input  enable,
        output short_press,
        output double_click,
        output long_press,
        output repeat_tick,
        output held
    );
endinterface

// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - debounced button level to short/double/long/repeat event pulses
module btn_event_decoder #(
    parameter int LONG_TIME   = 1_000_000,
    parameter int REPEAT_TIME = 200_000,
    parameter int DCLICK_TIME = 300_000,
    parameter bit DCLICK_EN   = 1'b1,
    parameter int CNT_W       = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    btn_event_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TIME - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG,
        S_WAIT2,
        S_WAIT_REL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q;
    logic             rise, fall;
    logic             short_d, dbl_d, long_d, rep_d, held_d;

    assign rise = bus.btn_level & ~btn_q;
    assign fall = ~bus.btn_level & btn_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        short_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rise) state_d = S_PRESSED;
            end
            S_PRESSED: begin
                // a release on the final count still counts as a short press
                if (fall) begin
                    if (DCLICK_EN) begin
                        state_d = S_WAIT2;
                    end else begin
                        state_d = S_IDLE;
                        short_d = 1'b1;
                    end
                end else if (cnt_q == LONG_LAST) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                end
            end
            S_LONG: begin
                if (fall) begin
                    state_d = S_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end
            end
            S_WAIT2: begin
                if (rise) begin
                    state_d = S_WAIT_REL;
                    dbl_d   = 1'b1;
                end else if (cnt_q == DCLICK_LAST) begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                end
            end
            S_WAIT_REL: begin
                cnt_d = '0;
                if (fall) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;

        if (!bus.enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            short_d = 1'b0;
            dbl_d   = 1'b0;
            long_d  = 1'b0;
            rep_d   = 1'b0;
        end

        held_d = (state_d == S_LONG);
    end

    // btn_q resets high so a button held through reset never looks like a new press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            btn_q            <= 1'b1;
            bus.short_press  <= 1'b0;
            bus.double_click <= 1'b0;
            bus.long_press   <= 1'b0;
            bus.repeat_tick  <= 1'b0;
            bus.held         <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            btn_q            <= bus.btn_level;
            bus.short_press  <= short_d;
            bus.double_click <= dbl_d;
            bus.long_press   <= long_d;
            bus.repeat_tick  <= rep_d;
            bus.held         <= held_d;
        end
    end

endmodule
